// File: rtl/pipeline_ctrl_if.sv
// Handshake bundle between the stage modules and pipeline_ctrl.
// The master side is the fetch/decode/ALU stages; the slave side is the controller.
interface pipeline_ctrl_if #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
);
  logic [DATA_W-1:0]     if_instr;
  logic [REG_ADDR_W-1:0] id_rs_addr;
  logic [REG_ADDR_W-1:0] id_rt_addr;
  logic                  id_uses_rs;
  logic                  id_uses_rt;
  logic [REG_ADDR_W-1:0] id_dst_addr;
  logic                  id_rf_wen;
  logic                  id_mem_rd;
  logic                  id_mem_wen;
  logic                  ex_branch_taken;

  logic [DATA_W-1:0]     id_instr;
  logic                  pc_ld_en;
  logic                  stall;
  logic                  flush;
  logic [1:0]            fwd_a_sel;
  logic [1:0]            fwd_b_sel;
  logic [REG_ADDR_W-1:0] ex_rs_addr;
  logic [REG_ADDR_W-1:0] ex_rt_addr;
  logic [REG_ADDR_W-1:0] ex_dst_addr;
  logic                  ex_rf_wen;
  logic                  ex_mem_rd;
  logic                  ex_mem_wen;
  logic [REG_ADDR_W-1:0] mem_dst_addr;
  logic                  mem_rf_wen;
  logic                  mem_mem_rd;
  logic                  mem_mem_wen;
  logic [REG_ADDR_W-1:0] wb_dst_addr;
  logic                  wb_rf_wen;
  logic [CNT_W-1:0]      stall_cnt;
  logic [CNT_W-1:0]      flush_cnt;

  modport master (
    output if_instr, id_rs_addr, id_rt_addr, id_uses_rs, id_uses_rt,
           id_dst_addr, id_rf_wen, id_mem_rd, id_mem_wen, ex_branch_taken,
    input  id_instr, pc_ld_en, stall, flush, fwd_a_sel, fwd_b_sel,
           ex_rs_addr, ex_rt_addr, ex_dst_addr, ex_rf_wen, ex_mem_rd, ex_mem_wen,
           mem_dst_addr, mem_rf_wen, mem_mem_rd, mem_mem_wen,
           wb_dst_addr, wb_rf_wen, stall_cnt, flush_cnt
  );

  modport slave (
    input  if_instr, id_rs_addr, id_rt_addr, id_uses_rs, id_uses_rt,
           id_dst_addr, id_rf_wen, id_mem_rd, id_mem_wen, ex_branch_taken,
    output id_instr, pc_ld_en, stall, flush, fwd_a_sel, fwd_b_sel,
           ex_rs_addr, ex_rt_addr, ex_dst_addr, ex_rf_wen, ex_mem_rd, ex_mem_wen,
           mem_dst_addr, mem_rf_wen, mem_mem_rd, mem_mem_wen,
           wb_dst_addr, wb_rf_wen, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Five-stage pipeline controller: IF/ID register, stage control fields, hazard stall/flush
// and ALU forwarding selects. Define PIPE_FWD_EN for forwarding; otherwise stall on any RAW.
module pipeline_ctrl #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input logic            Clk,
  input logic            Reset,
  pipeline_ctrl_if.slave bus
);
  logic [DATA_W-1:0]     r_id_instr;
  logic [REG_ADDR_W-1:0] r_ex_rs_addr, r_ex_rt_addr, r_ex_dst_addr;
  logic                  r_ex_rf_wen, r_ex_mem_rd, r_ex_mem_wen;
  logic [REG_ADDR_W-1:0] r_mem_dst_addr;
  logic                  r_mem_rf_wen, r_mem_mem_rd, r_mem_mem_wen;
  logic [REG_ADDR_W-1:0] r_wb_dst_addr;
  logic                  r_wb_rf_wen;
  logic [CNT_W-1:0]      r_stall_cnt, r_flush_cnt;

  logic [REG_ADDR_W-1:0] w_rs, w_rt;
  logic                  w_urs, w_urt;
  logic                  w_ex_hit, w_stall_req, w_stall, w_flush;
  logic [1:0]            w_fwd_a, w_fwd_b;

  assign w_rs  = bus.id_rs_addr;
  assign w_rt  = bus.id_rt_addr;
  assign w_urs = bus.id_uses_rs;
  assign w_urt = bus.id_uses_rt;

  // r0 is hardwired zero, so a producer writing it never creates a dependency.
  function automatic logic f_hit(input logic [REG_ADDR_W-1:0] dst, input logic wen);
    return wen && (dst != '0) &&
           ((w_urs && (dst == w_rs)) || (w_urt && (dst == w_rt)));
  endfunction

  assign w_ex_hit = f_hit(r_ex_dst_addr, r_ex_rf_wen);

`ifdef PIPE_FWD_EN
  function automatic logic [1:0] f_fwd(input logic [REG_ADDR_W-1:0] src);
    if (src == '0)                                return 2'b00;
    else if (r_mem_rf_wen && r_mem_dst_addr == src) return 2'b01;
    else if (r_wb_rf_wen && r_wb_dst_addr == src)   return 2'b10;
    else                                           return 2'b00;
  endfunction

  assign w_stall_req = r_ex_mem_rd & w_ex_hit;
  assign w_fwd_a     = f_fwd(r_ex_rs_addr);
  assign w_fwd_b     = f_fwd(r_ex_rt_addr);
`else
  logic w_mem_hit, w_wb_hit;

  // No write-through in the register file, so even WB producers must drain first.
  assign w_mem_hit   = f_hit(r_mem_dst_addr, r_mem_rf_wen);
  assign w_wb_hit    = f_hit(r_wb_dst_addr, r_wb_rf_wen);
  assign w_stall_req = w_ex_hit | w_mem_hit | w_wb_hit;
  assign w_fwd_a     = 2'b00;
  assign w_fwd_b     = 2'b00;
`endif

  assign w_flush = bus.ex_branch_taken;
  assign w_stall = w_stall_req & ~w_flush;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_id_instr     <= '0;
      r_ex_rs_addr   <= '0;
      r_ex_rt_addr   <= '0;
      r_ex_dst_addr  <= '0;
      r_ex_rf_wen    <= 1'b0;
      r_ex_mem_rd    <= 1'b0;
      r_ex_mem_wen   <= 1'b0;
      r_mem_dst_addr <= '0;
      r_mem_rf_wen   <= 1'b0;
      r_mem_mem_rd   <= 1'b0;
      r_mem_mem_wen  <= 1'b0;
      r_wb_dst_addr  <= '0;
      r_wb_rf_wen    <= 1'b0;
      r_stall_cnt    <= '0;
      r_flush_cnt    <= '0;
    end else begin
      if (w_flush)       r_id_instr <= '0;
      else if (!w_stall) r_id_instr <= bus.if_instr;

      if (w_flush || w_stall) begin
        r_ex_rs_addr  <= '0;
        r_ex_rt_addr  <= '0;
        r_ex_dst_addr <= '0;
        r_ex_rf_wen   <= 1'b0;
        r_ex_mem_rd   <= 1'b0;
        r_ex_mem_wen  <= 1'b0;
      end else begin
        r_ex_rs_addr  <= bus.id_rs_addr;
        r_ex_rt_addr  <= bus.id_rt_addr;
        r_ex_dst_addr <= bus.id_dst_addr;
        r_ex_rf_wen   <= bus.id_rf_wen;
        r_ex_mem_rd   <= bus.id_mem_rd;
        r_ex_mem_wen  <= bus.id_mem_wen;
      end

      r_mem_dst_addr <= r_ex_dst_addr;
      r_mem_rf_wen   <= r_ex_rf_wen;
      r_mem_mem_rd   <= r_ex_mem_rd;
      r_mem_mem_wen  <= r_ex_mem_wen;
      r_wb_dst_addr  <= r_mem_dst_addr;
      r_wb_rf_wen    <= r_mem_rf_wen;

      if (w_stall && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_flush && r_flush_cnt != '1) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign bus.id_instr     = r_id_instr;
  assign bus.pc_ld_en     = ~w_stall;
  assign bus.stall        = w_stall;
  assign bus.flush        = w_flush;
  assign bus.fwd_a_sel    = w_fwd_a;
  assign bus.fwd_b_sel    = w_fwd_b;
  assign bus.ex_rs_addr   = r_ex_rs_addr;
  assign bus.ex_rt_addr   = r_ex_rt_addr;
  assign bus.ex_dst_addr  = r_ex_dst_addr;
  assign bus.ex_rf_wen    = r_ex_rf_wen;
  assign bus.ex_mem_rd    = r_ex_mem_rd;
  assign bus.ex_mem_wen   = r_ex_mem_wen;
  assign bus.mem_dst_addr = r_mem_dst_addr;
  assign bus.mem_rf_wen   = r_mem_rf_wen;
  assign bus.mem_mem_rd   = r_mem_mem_rd;
  assign bus.mem_mem_wen  = r_mem_mem_wen;
  assign bus.wb_dst_addr  = r_wb_dst_addr;
  assign bus.wb_rf_wen    = r_wb_rf_wen;
  assign bus.stall_cnt    = r_stall_cnt;
  assign bus.flush_cnt    = r_flush_cnt;
endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl; counters narrowed to 4 bits so saturation is reachable.
// Expectations follow the forwarding build when PIPE_FWD_EN is defined, the stalling build otherwise.
module tb_pipeline_ctrl;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

  pipeline_ctrl_if #(.DATA_W(32), .REG_ADDR_W(5), .CNT_W(CNT_W)) bus();

  pipeline_ctrl #(.DATA_W(32), .REG_ADDR_W(5), .CNT_W(CNT_W)) dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] instr, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt, input logic [4:0] dst,
                       input logic wen, input logic mrd, input logic mwen);
    bus.if_instr    = instr;
    bus.id_rs_addr  = rs;
    bus.id_rt_addr  = rt;
    bus.id_uses_rs  = urs;
    bus.id_uses_rt  = urt;
    bus.id_dst_addr = dst;
    bus.id_rf_wen   = wen;
    bus.id_mem_rd   = mrd;
    bus.id_mem_wen  = mwen;
    #1;
  endtask

  task automatic idle(input int n);
    bus.ex_branch_taken = 1'b0;
    drive(32'h0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    repeat (n) tick();
  endtask

  initial begin
    bus.ex_branch_taken = 1'b0;
    drive(32'h0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);

    // reset held two cycles under random inputs
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      bus.ex_branch_taken = 1'($urandom_range(0, 1));
      drive($urandom, 5'($urandom), 5'($urandom), 1'($urandom), 1'($urandom),
            5'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      tick();
    end
    idle(0);
    chk("rst_id_instr", bus.id_instr, 32'h0);
    chk("rst_ex_rf_wen", bus.ex_rf_wen, 0);
    chk("rst_ex_dst", bus.ex_dst_addr, 0);
    chk("rst_mem_rf_wen", bus.mem_rf_wen, 0);
    chk("rst_wb_rf_wen", bus.wb_rf_wen, 0);
    chk("rst_stall_cnt", bus.stall_cnt, 0);
    chk("rst_flush_cnt", bus.flush_cnt, 0);
    chk("rst_pc_ld_en", bus.pc_ld_en, 1);
    rst = 1'b0;
    idle(1);

    // ADD r3 then SUB reading r3 as rs
    drive(32'h0A, 5'd0, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0);
    chk("add_stall", bus.stall, 0);
    tick();
    chk("add_id_instr", bus.id_instr, 32'h0A);
    chk("add_ex_dst", bus.ex_dst_addr, 3);
    chk("add_ex_rf_wen", bus.ex_rf_wen, 1);
    drive(32'h0B, 5'd3, 5'd4, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
`ifdef PIPE_FWD_EN
    chk("sub_stall", bus.stall, 0);
    chk("sub_pc_ld_en", bus.pc_ld_en, 1);
    tick();
    chk("sub_id_instr", bus.id_instr, 32'h0B);
    chk("sub_ex_rs", bus.ex_rs_addr, 3);
    chk("sub_fwd_a", bus.fwd_a_sel, 2'b01);
    chk("sub_fwd_b", bus.fwd_b_sel, 2'b00);
`else
    chk("sub_stall1", bus.stall, 1);
    chk("sub_pc_ld_en1", bus.pc_ld_en, 0);
    chk("sub_fwd_a", bus.fwd_a_sel, 2'b00);
    tick();
    chk("sub_id_hold", bus.id_instr, 32'h0A);
    chk("sub_bubble_wen", bus.ex_rf_wen, 0);
    chk("sub_bubble_dst", bus.ex_dst_addr, 0);
    chk("sub_mem_dst", bus.mem_dst_addr, 3);
    chk("sub_mem_rf_wen", bus.mem_rf_wen, 1);
    chk("sub_stall_cnt1", bus.stall_cnt, 1);
    chk("sub_stall2", bus.stall, 1);
    tick();
    chk("sub_wb_rf_wen", bus.wb_rf_wen, 1);
    chk("sub_stall3", bus.stall, 1);
    tick();
    chk("sub_stall_end", bus.stall, 0);
    chk("sub_pc_ld_en_end", bus.pc_ld_en, 1);
    chk("sub_stall_cnt3", bus.stall_cnt, 3);
    tick();
    chk("sub_id_instr", bus.id_instr, 32'h0B);
    chk("sub_ex_rs", bus.ex_rs_addr, 3);
    chk("sub_ex_dst", bus.ex_dst_addr, 6);
    chk("sub_fwd_a_tied", bus.fwd_a_sel, 2'b00);
`endif
    idle(3);

    // ADD r3, unrelated, SUB reading r3
    drive(32'h1A, 5'd0, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0);
    tick();
    drive(32'h1B, 5'd0, 5'd0, 1'b0, 1'b0, 5'd10, 1'b1, 1'b0, 1'b0);
    tick();
    drive(32'h1C, 5'd3, 5'd0, 1'b1, 1'b0, 5'd11, 1'b1, 1'b0, 1'b0);
`ifdef PIPE_FWD_EN
    chk("gap_stall", bus.stall, 0);
    tick();
    chk("gap_fwd_a", bus.fwd_a_sel, 2'b10);
`else
    chk("gap_stall1", bus.stall, 1);
    tick();
    chk("gap_stall2", bus.stall, 1);
    tick();
    chk("gap_stall_end", bus.stall, 0);
    chk("gap_stall_cnt", bus.stall_cnt, 5);
`endif
    idle(3);

    // LW r5 then ADD reading r5 as rt
    drive(32'h0C, 5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
    tick();
    drive(32'h0D, 5'd2, 5'd5, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
    chk("lu_stall", bus.stall, 1);
    chk("lu_pc_ld_en", bus.pc_ld_en, 0);
    tick();
    chk("lu_bubble_wen", bus.ex_rf_wen, 0);
    chk("lu_id_hold", bus.id_instr, 32'h0C);
    chk("lu_mem_mem_rd", bus.mem_mem_rd, 1);
`ifdef PIPE_FWD_EN
    chk("lu_stall_once", bus.stall, 0);
    chk("lu_fwd_b_bubble", bus.fwd_b_sel, 2'b00);
    chk("lu_stall_cnt", bus.stall_cnt, 1);
    tick();
    chk("lu_ex_rt", bus.ex_rt_addr, 5);
    chk("lu_fwd_b", bus.fwd_b_sel, 2'b10);
    chk("lu_fwd_a", bus.fwd_a_sel, 2'b00);
`else
    chk("lu_stall2", bus.stall, 1);
    tick();
    chk("lu_stall3", bus.stall, 1);
    tick();
    chk("lu_stall_end", bus.stall, 0);
    chk("lu_stall_cnt", bus.stall_cnt, 8);
`endif
    idle(3);

    // store then load reading the same register: no stall
    drive(32'h20, 5'd0, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b1);
    tick();
    chk("sw_ex_mem_wen", bus.ex_mem_wen, 1);
    drive(32'h21, 5'd7, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b1, 1'b0);
    chk("sw_lw_stall", bus.stall, 0);
    idle(3);

    // address match on a source the ID instruction does not read
    drive(32'h22, 5'd0, 5'd0, 1'b0, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0);
    tick();
    drive(32'h23, 5'd8, 5'd8, 1'b0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0);
    chk("unused_src_stall", bus.stall, 0);
    idle(3);

    // writes to r0 in EX and MEM, consumer reads r0
    drive(32'h24, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
    tick();
    drive(32'h25, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
    tick();
    drive(32'h26, 5'd0, 5'd0, 1'b1, 1'b1, 5'd1, 1'b1, 1'b0, 1'b0);
    chk("r0_stall", bus.stall, 0);
    tick();
    chk("r0_fwd_a", bus.fwd_a_sel, 2'b00);
    chk("r0_fwd_b", bus.fwd_b_sel, 2'b00);
    idle(3);

    // flush in the same cycle as a load-use match
    drive(32'h30, 5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
    tick();
    drive(32'h0E, 5'd0, 5'd5, 1'b0, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
    bus.ex_branch_taken = 1'b1;
    #1;
    chk("fl_stall", bus.stall, 0);
    chk("fl_flush", bus.flush, 1);
    chk("fl_pc_ld_en", bus.pc_ld_en, 1);
    tick();
    chk("fl_id_instr", bus.id_instr, 32'h0);
    chk("fl_ex_rf_wen", bus.ex_rf_wen, 0);
    chk("fl_ex_dst", bus.ex_dst_addr, 0);
    chk("fl_mem_mem_rd", bus.mem_mem_rd, 1);
    chk("fl_flush_cnt", bus.flush_cnt, 1);
`ifdef PIPE_FWD_EN
    chk("fl_stall_cnt", bus.stall_cnt, 1);
`else
    chk("fl_stall_cnt", bus.stall_cnt, 8);
`endif
    idle(3);

    // back-to-back flushes
    drive(32'h0F, 5'd0, 5'd0, 1'b0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0);
    bus.ex_branch_taken = 1'b1;
    tick();
    chk("fl2_id_instr_a", bus.id_instr, 32'h0);
    chk("fl2_ex_rf_wen", bus.ex_rf_wen, 0);
    tick();
    chk("fl2_id_instr_b", bus.id_instr, 32'h0);
    chk("fl2_flush_cnt", bus.flush_cnt, 3);
    bus.ex_branch_taken = 1'b0;
    drive(32'h10, 5'd0, 5'd0, 1'b0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0);
    tick();
    chk("fl2_resume", bus.id_instr, 32'h10);
    idle(3);

    // counter saturation
    for (int i = 0; i < 20; i++) begin
      drive(32'h40, 5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
      tick();
      drive(32'h41, 5'd0, 5'd5, 1'b0, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
      repeat (4) tick();
    end
    chk("sat_stall_cnt", bus.stall_cnt, 15);
    idle(3);
    bus.ex_branch_taken = 1'b1;
    repeat (20) tick();
    chk("sat_flush_cnt", bus.flush_cnt, 15);
    idle(3);

    // reset asserted in the middle of a stall
    drive(32'h50, 5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
    tick();
    drive(32'h51, 5'd5, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0);
    chk("mid_stall", bus.stall, 1);
    rst = 1'b1;
    tick();
    chk("mid_rst_id_instr", bus.id_instr, 32'h0);
    chk("mid_rst_mem_rf_wen", bus.mem_rf_wen, 0);
    chk("mid_rst_mem_dst", bus.mem_dst_addr, 0);
    chk("mid_rst_stall_cnt", bus.stall_cnt, 0);
    chk("mid_rst_flush_cnt", bus.flush_cnt, 0);
    rst = 1'b0;
    idle(1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
